// File: rtl/layer_mem_if.sv
// Requester-side bus of the layer-memory arbiter. All per-requester fields are
// packed vectors, with requester i using slice [i*W +: W].
//
// Handshake: a requester holds req_valid and its beat fields stable until it
// sees req_ready; a beat is accepted in any cycle where req_valid[i] and
// req_ready[i] are both high. rsp_valid and req_err are one-cycle pulses that
// need no acknowledgement.
interface layer_mem_if #(
    parameter int NREQ = 3,
    parameter int AW   = 12,
    parameter int DW   = 20,
    parameter int SELW = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*SELW-1:0] req_sel;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic [NREQ-1:0]      req_err;

    modport master (
        output req_valid, req_we, req_lock, req_sel, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, req_err
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_sel, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, req_err
    );
endinterface

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing one layer-memory port among NREQ requesters.
// One beat per cycle, optional grant lock for multi-beat sequences, registered
// memory-side outputs, and read data routed back to its owner two cycles after
// the beat via a two-stage requester tag pipeline.
// A beat with an illegal select is consumed without touching the memory: no
// strobe, csel unchanged, req_err pulse, and it never holds a lock.
module layer_mem_arbiter #(
    parameter int NREQ    = 3,
    parameter int AW      = 12,
    parameter int DW      = 20,
    parameter int SELW    = 3,
    parameter int SEL_MAX = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    layer_mem_if.slave      bus,
    output logic            cwr,
    output logic            crd,
    output logic [SELW-1:0] csel,
    output logic [AW-1:0]   caddr_wr,
    output logic [AW-1:0]   caddr_rd,
    output logic [DW-1:0]   cdata_wr,
    input  logic [DW-1:0]   cdata_rd,
    output logic            idle
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [0:0] {ST_ARB, ST_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            cwr_q, cwr_d;
    logic            crd_q, crd_d;
    logic [SELW-1:0] csel_q, csel_d;
    logic [AW-1:0]   caddr_wr_q, caddr_wr_d;
    logic [AW-1:0]   caddr_rd_q, caddr_rd_d;
    logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
    logic [NREQ-1:0] err_q, err_d;
    logic            tag1_v_q, tag1_v_d;
    logic [PW-1:0]   tag1_id_q, tag1_id_d;
    logic            tag2_v_q, tag2_v_d;
    logic [PW-1:0]   tag2_id_q, tag2_id_d;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   ptr_next;
    logic [SELW-1:0] beat_sel;
    logic [AW-1:0]   beat_addr;
    logic [DW-1:0]   beat_wdata;
    logic            beat_we;
    logic            beat_lock;
    logic            beat_legal;
    int              cand;

    // Pick the granted requester: lock owner only while locked, else first valid from the pointer with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        if (state_q == ST_LOCKED) begin
            if (bus.req_valid[owner_q]) begin
                gnt_found = 1'b1;
                gnt_idx   = owner_q;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = (int'(ptr_q) + k) % NREQ;
                if (!gnt_found && bus.req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PW'(cand);
                end
            end
        end
        // Nobody is granted while reset is held, even with requests pending.
        if (!reset_n) begin
            gnt_found = 1'b0;
        end
    end

    // Extract the granted beat's fields and classify the select.
    always_comb begin
        beat_sel   = bus.req_sel[gnt_idx*SELW +: SELW];
        beat_addr  = bus.req_addr[gnt_idx*AW +: AW];
        beat_wdata = bus.req_wdata[gnt_idx*DW +: DW];
        beat_we    = bus.req_we[gnt_idx];
        beat_lock  = bus.req_lock[gnt_idx];
        beat_legal = (beat_sel != '0) && (beat_sel <= SELW'(SEL_MAX));
        ptr_next   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Next state for the lock FSM, pointer, memory outputs, error pulse and read tags.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cwr_d      = 1'b0;
        crd_d      = 1'b0;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        cdata_wr_d = cdata_wr_q;
        err_d      = '0;
        tag1_v_d   = 1'b0;
        tag1_id_d  = tag1_id_q;
        tag2_v_d   = tag1_v_q;
        tag2_id_d  = tag1_id_q;
        if (gnt_found) begin
            if (beat_legal) begin
                csel_d = beat_sel;
                if (beat_we) begin
                    cwr_d      = 1'b1;
                    caddr_wr_d = beat_addr;
                    cdata_wr_d = beat_wdata;
                end else begin
                    crd_d      = 1'b1;
                    caddr_rd_d = beat_addr;
                    tag1_v_d   = 1'b1;
                    tag1_id_d  = gnt_idx;
                end
            end else begin
                err_d[gnt_idx] = 1'b1;
            end
            if (beat_legal && beat_lock) begin
                // Pointer holds while a lock sequence is in progress.
                state_d = ST_LOCKED;
                owner_d = gnt_idx;
            end else begin
                state_d = ST_ARB;
                ptr_d   = ptr_next;
            end
        end
    end

    // State register; asynchronous reset drops locks and any in-flight read tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ARB;
            owner_q    <= '0;
            ptr_q      <= '0;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= '0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            err_q      <= '0;
            tag1_v_q   <= 1'b0;
            tag1_id_q  <= '0;
            tag2_v_q   <= 1'b0;
            tag2_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
            cdata_wr_q <= cdata_wr_d;
            err_q      <= err_d;
            tag1_v_q   <= tag1_v_d;
            tag1_id_q  <= tag1_id_d;
            tag2_v_q   <= tag2_v_d;
            tag2_id_q  <= tag2_id_d;
        end
    end

    // Drive grants, read responses, memory outputs and idle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = gnt_found && (gnt_idx == PW'(i));
            bus.rsp_valid[i] = tag2_v_q && (tag2_id_q == PW'(i));
        end
        bus.rsp_data = cdata_rd;
        bus.req_err  = err_q;
        cwr          = cwr_q;
        crd          = crd_q;
        csel         = csel_q;
        caddr_wr     = caddr_wr_q;
        caddr_rd     = caddr_rd_q;
        cdata_wr     = cdata_wr_q;
        idle         = (bus.req_valid == '0) && !tag1_v_q && !tag2_v_q && !cwr_q && !crd_q;
    end
endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Randomized bench for layer_mem_arbiter checked cycle by cycle against a
// transaction-level model: grant from a rotating priority list, expected
// memory registers after each beat, and a queue of outstanding reads with the
// cycle they were issued.
module tb_layer_mem_arbiter;
    localparam int NREQ    = 3;
    localparam int AW      = 12;
    localparam int DW      = 20;
    localparam int SELW    = 3;
    localparam int SEL_MAX = 5;

    // Clock/reset
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic            cwr, crd, idle;
    logic [SELW-1:0] csel;
    logic [AW-1:0]   caddr_wr, caddr_rd;
    logic [DW-1:0]   cdata_wr, cdata_rd;

    layer_mem_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .SELW(SELW)) bus ();

    layer_mem_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .SELW(SELW), .SEL_MAX(SEL_MAX)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .cwr      (cwr),
        .crd      (crd),
        .csel     (csel),
        .caddr_wr (caddr_wr),
        .caddr_rd (caddr_rd),
        .cdata_wr (cdata_wr),
        .cdata_rd (cdata_rd),
        .idle     (idle)
    );

    // Stimulus for the current cycle
    logic [NREQ-1:0] v, we, lk;
    logic [SELW-1:0] sel [NREQ];
    logic [AW-1:0]   addr [NREQ];
    logic [DW-1:0]   wd [NREQ];

    // Reference model
    int              m_ptr;
    bit              m_locked;
    int              m_owner;
    logic            e_cwr, e_crd;
    logic [SELW-1:0] e_csel;
    logic [AW-1:0]   e_caddr_wr, e_caddr_rd;
    logic [DW-1:0]   e_cdata_wr;
    logic [NREQ-1:0] e_err;
    int              pend_id [$];
    int              pend_cyc [$];
    int              cyc;

    // Scoreboard counters
    int tests_run;
    int tests_failed;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [SELW-1:0] rand_sel();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return SELW'($urandom_range(1, SEL_MAX));
        if (r == 7) return '0;
        if (r == 8) return SELW'(6);
        return SELW'(7);
    endfunction

    task automatic model_reset();
        m_ptr      = 0;
        m_locked   = 0;
        m_owner    = 0;
        e_cwr      = 0;
        e_crd      = 0;
        e_csel     = '0;
        e_caddr_wr = '0;
        e_caddr_rd = '0;
        e_cdata_wr = '0;
        e_err      = '0;
        pend_id.delete();
        pend_cyc.delete();
    endtask

    // Modes: 0 random, 1 all write legal, 2 lock-heavy reads, 3 quiet, 4 requester 0 single read
    task automatic gen_inputs(input int mode);
        for (int i = 0; i < NREQ; i++) begin
            addr[i] = AW'($urandom);
            wd[i]   = DW'($urandom);
            case (mode)
                0: begin
                    v[i] = ($urandom_range(0, 3) != 0); we[i] = $urandom_range(0, 1) == 1;
                    lk[i] = ($urandom_range(0, 3) == 0); sel[i] = rand_sel();
                end
                1: begin
                    v[i] = 1'b1; we[i] = 1'b1; lk[i] = 1'b0;
                    sel[i] = SELW'($urandom_range(1, SEL_MAX));
                end
                2: begin
                    v[i] = ($urandom_range(0, 9) < 7); we[i] = 1'b0;
                    lk[i] = $urandom_range(0, 1) == 1; sel[i] = rand_sel();
                end
                4: begin
                    v[i] = (i == 0); we[i] = 1'b0; lk[i] = 1'b0; sel[i] = SELW'(1);
                    addr[i] = 12'h041;
                end
                default: begin
                    v[i] = 1'b0; we[i] = 1'b0; lk[i] = 1'b0; sel[i] = SELW'(1);
                end
            endcase
            bus.req_sel[i*SELW +: SELW] = sel[i];
            bus.req_addr[i*AW +: AW]    = addr[i];
            bus.req_wdata[i*DW +: DW]   = wd[i];
        end
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_lock  = lk;
        cdata_rd      = DW'($urandom);
    endtask

    // Driver: one active cycle with model-based checks
    task automatic step(input int mode);
        bit              found;
        int              g;
        logic [NREQ-1:0] e_rdy, e_rsp;
        bit              legal;
        bit              e_idle;
        @(negedge clk);
        reset_n = 1'b1;
        gen_inputs(mode);
        #1;
        found = 0;
        g     = 0;
        if (m_locked) begin
            if (v[m_owner]) begin found = 1; g = m_owner; end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (!found && v[j]) begin found = 1; g = j; end
            end
        end
        e_rdy = '0;
        if (found) e_rdy[g] = 1'b1;
        e_idle = (v == '0) && (pend_cyc.size() == 0) && !e_cwr && !e_crd;
        e_rsp = '0;
        if (pend_cyc.size() > 0 && pend_cyc[0] + 2 == cyc) begin
            e_rsp[pend_id[0]] = 1'b1;
            void'(pend_id.pop_front());
            void'(pend_cyc.pop_front());
        end
        check_eq("req_ready", 32'(bus.req_ready), 32'(e_rdy));
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
        if (e_rsp != '0) check_eq("rsp_data", 32'(bus.rsp_data), 32'(cdata_rd));
        check_eq("req_err", 32'(bus.req_err), 32'(e_err));
        check_eq("cwr", 32'(cwr), 32'(e_cwr));
        check_eq("crd", 32'(crd), 32'(e_crd));
        check_eq("csel", 32'(csel), 32'(e_csel));
        check_eq("caddr_wr", 32'(caddr_wr), 32'(e_caddr_wr));
        check_eq("caddr_rd", 32'(caddr_rd), 32'(e_caddr_rd));
        check_eq("cdata_wr", 32'(cdata_wr), 32'(e_cdata_wr));
        check_eq("idle", 32'(idle), 32'(e_idle));
        // Advance the model by the beat accepted at the coming edge
        e_cwr = 0;
        e_crd = 0;
        e_err = '0;
        if (found) begin
            legal = (sel[g] != 0) && (sel[g] <= SEL_MAX);
            if (legal) begin
                e_csel = sel[g];
                if (we[g]) begin
                    e_cwr = 1; e_caddr_wr = addr[g]; e_cdata_wr = wd[g];
                end else begin
                    e_crd = 1; e_caddr_rd = addr[g];
                    pend_id.push_back(g);
                    pend_cyc.push_back(cyc);
                end
            end else begin
                e_err[g] = 1'b1;
            end
            if (legal && lk[g]) begin
                m_locked = 1; m_owner = g;
            end else begin
                m_locked = 0; m_ptr = (g + 1) % NREQ;
            end
        end
        cyc++;
    endtask

    // Driver: cycles with reset held and every requester asking
    task automatic reset_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            reset_n = 1'b0;
            gen_inputs(1);
            #1;
            model_reset();
            check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check_eq("rst_req_err", 32'(bus.req_err), 32'd0);
            check_eq("rst_mem_out", 32'({cwr, crd, csel}), 32'd0);
            check_eq("rst_caddr", 32'({caddr_wr, caddr_rd}), 32'd0);
            check_eq("rst_cdata_wr", 32'(cdata_wr), 32'd0);
            cyc++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        reset_n      = 1'b0;
        model_reset();
        reset_cycles(3);
        for (int i = 0; i < 9; i++) step(1);
        for (int i = 0; i < 400; i++) step(0);
        for (int i = 0; i < 200; i++) step(2);
        step(3);
        step(3);
        step(4);
        reset_cycles(2);
        for (int i = 0; i < 4; i++) step(3);
        step(4);
        for (int i = 0; i < 4; i++) step(3);
        for (int i = 0; i < 300; i++) step(0);
        for (int i = 0; i < 4; i++) step(3);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
